// File: rtl/bbs_stream_gen_if.sv
// ----------------------------------------------------------------------------
// bbs_stream_gen_if
//
// Valid/ready word stream carrying packed Blum-Blum-Shub output words.
//
// Signals:
//   out_data   OUT_W  packed word, oldest extracted bit in the MSB
//   out_valid  1      out_data holds a complete word
//   out_ready  1      consumer accepts the word when out_valid && out_ready
//
// Modports:
//   master  generator side (drives out_data/out_valid, samples out_ready)
//   slave   consumer side
//
// OUT_W must match the OUT_W of the bbs_stream_gen instance it is bound to.
// ----------------------------------------------------------------------------
interface bbs_stream_gen_if #(
    parameter int OUT_W = 8
) ();
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/bbs_stream_gen.sv
// ----------------------------------------------------------------------------
// bbs_stream_gen
//
// Blum-Blum-Shub pseudo-random word generator. Each step computes
// x <= x^2 mod MOD with a bit-serial shift-add modular squarer (one
// multiplier bit per cycle, SIZE cycles), commits the new x, extracts one
// bit from it and shifts that bit into a word. Every OUT_W steps the word is
// presented on a valid/ready stream and held until accepted.
//
// Parameters:
//   SIZE   width of the state x and of the modulus
//   The modulus parameter must satisfy 2 < MOD < 2^SIZE
//   SEED   state loaded at reset and substituted for invalid seeds
//   OUT_W  bits per output word, 2..64
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   enable     generation permitted while high; a step in progress always
//              completes, and a partial word is kept while idle
//   seed_load  single-cycle pulse, loads seed_in (highest priority)
//   seed_in    new seed; values < 2 or >= MOD are replaced by SEED
//   busy       high while squaring or committing
//   state_out  last committed x (never a partial accumulator)
//   stream     bbs_stream_gen_if.master: out_data / out_valid / out_ready
//
// Build option:
//   BBS_PARITY_EN  when defined, the extracted bit is the XOR of all bits of
//                  the new x; otherwise it is the LSB of the new x.
// ----------------------------------------------------------------------------
module bbs_stream_gen #(
    parameter int SIZE  = 16,
    parameter int MOD   = 40633,
    parameter int SEED  = 884,
    parameter int OUT_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    seed_load,
    input  logic [SIZE-1:0]         seed_in,
    output logic                    busy,
    output logic [SIZE-1:0]         state_out,
    bbs_stream_gen_if.master        stream
);

    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    localparam logic [SIZE:0]      MOD_A    = (SIZE+1)'(MOD);
    localparam logic [SIZE-1:0]    SEED_X   = SIZE'(SEED);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(SIZE - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(OUT_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SQUARE = 2'd1,
        COMMIT = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [SIZE-1:0]    x;
    logic [SIZE:0]      acc;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   cnt;
    logic [OUT_W-1:0]   word;
    logic [OUT_W-1:0]   out_data;
    logic               out_valid;

    logic [SIZE:0]      acc_dbl;
    logic [SIZE:0]      acc_nxt;
    logic [SIZE-1:0]    x_new;
    logic [OUT_W-1:0]   word_new;
    logic               word_done;

    // Operands are always < MOD on entry, so a single conditional subtract
    // brings any sum of two residues back into range.
    function automatic logic [SIZE:0] mod_reduce(input logic [SIZE:0] v);
        return (v >= MOD_A) ? (v - MOD_A) : v;
    endfunction

    function automatic logic [SIZE-1:0] seed_sanitize(input logic [SIZE-1:0] s);
        if ((s < SIZE'(2)) || ({1'b0, s} >= MOD_A))
            return SEED_X;
        return s;
    endfunction

    function automatic logic extract_bit(input logic [SIZE-1:0] v);
`ifdef BBS_PARITY_EN
        return ^v;
`else
        return v[0];
`endif
    endfunction

    // Squarer iteration: acc = 2*acc mod MOD, then + x mod MOD if x[idx].
    // acc < MOD < 2^SIZE, so the shift never loses a set bit.
    always_comb begin
        acc_dbl = mod_reduce(acc << 1);
        acc_nxt = acc_dbl;
        if (x[idx])
            acc_nxt = mod_reduce(acc_dbl + {1'b0, x});
    end

    assign x_new     = acc[SIZE-1:0];
    assign word_new  = {word[OUT_W-2:0], extract_bit(x_new)};
    assign word_done = (cnt == CNT_LAST);

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (enable)
                    state_nxt = SQUARE;
            end
            SQUARE: begin
                if (idx == '0)
                    state_nxt = COMMIT;
            end
            COMMIT: begin
                if (word_done)
                    state_nxt = HOLD;
                else if (enable)
                    state_nxt = SQUARE;
                else
                    state_nxt = IDLE;
            end
            HOLD: begin
                if (stream.out_ready)
                    state_nxt = enable ? SQUARE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (seed_load)
            state_nxt = IDLE;
    end

    // Datapath: squarer, committed state, word packing, output register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x         <= SEED_X;
            acc       <= '0;
            idx       <= IDX_LAST;
            cnt       <= '0;
            word      <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (seed_load) begin
            x         <= seed_sanitize(seed_in);
            acc       <= '0;
            idx       <= IDX_LAST;
            cnt       <= '0;
            word      <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                SQUARE: begin
                    acc <= acc_nxt;
                    idx <= idx - IDX_W'(1);
                end
                COMMIT: begin
                    x    <= x_new;
                    word <= word_new;
                    acc  <= '0;
                    idx  <= IDX_LAST;
                    if (word_done) begin
                        cnt       <= '0;
                        out_data  <= word_new;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (stream.out_ready)
                        out_valid <= 1'b0;
                end
                default: begin
                    acc <= '0;
                    idx <= IDX_LAST;
                end
            endcase
        end
    end

    assign busy             = (state == SQUARE) || (state == COMMIT);
    assign state_out        = x;
    assign stream.out_data  = out_data;
    assign stream.out_valid = out_valid;

endmodule

// File: tb/tb_bbs_stream_gen.sv
// ----------------------------------------------------------------------------
// tb_bbs_stream_gen
//
// Bench for bbs_stream_gen with SIZE=16, MOD=40633, SEED=884, OUT_W=4.
// Expected words come from a behavioural x^2 mod MOD model and are queued
// when generation is started; they are popped when the DUT presents a word.
// ----------------------------------------------------------------------------
module tb_bbs_stream_gen;

    localparam int SIZE  = 16;
    localparam int MOD   = 40633;
    localparam int SEED  = 884;
    localparam int OUT_W = 4;
    localparam int STEP  = SIZE + 1;
    localparam int FIRST = OUT_W * STEP + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              seed_load;
    logic [SIZE-1:0]   seed_in;
    logic              busy;
    logic [SIZE-1:0]   state_out;

    int                checks   = 0;
    int                failures = 0;
    logic [31:0]       exp_q[$];

    bbs_stream_gen_if #(.OUT_W(OUT_W)) sif ();

    bbs_stream_gen #(
        .SIZE  (SIZE),
        .MOD   (MOD),
        .SEED  (SEED),
        .OUT_W (OUT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .busy      (busy),
        .state_out (state_out),
        .stream    (sif)
    );

    always #5 clk = ~clk;

    function automatic logic [SIZE-1:0] m_next(input logic [SIZE-1:0] v);
        longint t;
        t = longint'(v) * longint'(v);
        return SIZE'(t % MOD);
    endfunction

    function automatic logic m_bit(input logic [SIZE-1:0] v);
`ifdef BBS_PARITY_EN
        return ^v;
`else
        return v[0];
`endif
    endfunction

    task automatic push_words(input logic [SIZE-1:0] x0, input int n);
        logic [SIZE-1:0]  v;
        logic [OUT_W-1:0] w;
        v = x0;
        for (int k = 0; k < n; k++) begin
            w = '0;
            for (int j = 0; j < OUT_W; j++) begin
                v = m_next(v);
                w = {w[OUT_W-2:0], m_bit(v)};
            end
            exp_q.push_back({{(32-OUT_W){1'b0}}, w});
        end
    endtask

    function automatic logic [31:0] sb_pop();
        if (exp_q.size() == 0)
            return 32'hFFFF_FFFF;
        return exp_q.pop_front();
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns the tick number at which out_valid was first seen, or -1.
    task automatic wait_valid(input int budget, output int cyc);
        int n;
        cyc = -1;
        n = 0;
        while (cyc < 0 && n < budget) begin
            tick();
            n++;
            if (sif.out_valid === 1'b1)
                cyc = n;
        end
    endtask

    task automatic do_seed(input logic [SIZE-1:0] s);
        seed_in   = s;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
    endtask

    task automatic test_reset();
        reset         = 1'b0;
        enable        = 1'b0;
        seed_load     = 1'b0;
        seed_in       = '0;
        sif.out_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if (sif.out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%0b exp=0", sif.out_valid);
        end
        checks++;
        if (sif.out_data !== 4'h0) begin
            failures++; $display("FAIL reset_data got=%0h exp=0", sif.out_data);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL reset_busy got=%0b exp=0", busy);
        end
        checks++;
        if (state_out !== 16'd884) begin
            failures++; $display("FAIL reset_state got=%0d exp=884", state_out);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_first_word();
        logic [SIZE-1:0] ex [4];
        logic [SIZE-1:0] prev;
        logic [31:0]     ew;
        int              k;
        int              cyc;
        logic            saw_busy;
        ex = '{16'd9429, 16'd1037, 16'd18911, 16'd14888};
        k        = 0;
        cyc      = -1;
        saw_busy = 1'b0;
        prev     = state_out;
        push_words(16'(SEED), 2);
        enable        = 1'b1;
        sif.out_ready = 1'b1;
        for (int n = 1; n <= 200 && cyc < 0; n++) begin
            tick();
            if (busy === 1'b1)
                saw_busy = 1'b1;
            if (state_out !== prev) begin
                if (k < 4) begin
                    checks++;
                    if (state_out !== ex[k]) begin
                        failures++; $display("FAIL commit_x%0d got=%0d exp=%0d", k, state_out, ex[k]);
                    end
                end
                k++;
                prev = state_out;
            end
            if (sif.out_valid === 1'b1)
                cyc = n;
        end
        checks++;
        if (cyc !== FIRST) begin
            failures++; $display("FAIL first_latency got=%0d exp=%0d", cyc, FIRST);
        end
        checks++;
        if (k !== 4) begin
            failures++; $display("FAIL commit_count got=%0d exp=4", k);
        end
        checks++;
        if (saw_busy !== 1'b1) begin
            failures++; $display("FAIL busy_seen got=%0b exp=1", saw_busy);
        end
        ew = sb_pop();
        checks++;
        if ({28'b0, sif.out_data} !== ew) begin
            failures++; $display("FAIL first_word got=%0h exp=%0h", sif.out_data, ew);
        end
`ifdef BBS_PARITY_EN
        checks++;
        if (sif.out_data[3:2] !== 2'b10) begin
            failures++; $display("FAIL parity_bits got=%0b exp=10", sif.out_data[3:2]);
        end
`else
        checks++;
        if (sif.out_data !== 4'hE) begin
            failures++; $display("FAIL first_word_const got=%0h exp=e", sif.out_data);
        end
`endif
        tick();
        checks++;
        if (sif.out_valid !== 1'b0) begin
            failures++; $display("FAIL valid_one_cycle got=%0b exp=0", sif.out_valid);
        end
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL restart_busy got=%0b exp=1", busy);
        end
        wait_valid(FIRST + 10, cyc);
        checks++;
        if (cyc !== FIRST - 1) begin
            failures++; $display("FAIL back_to_back_period got=%0d exp=%0d", cyc, FIRST - 1);
        end
        ew = sb_pop();
        checks++;
        if ({28'b0, sif.out_data} !== ew) begin
            failures++; $display("FAIL second_word got=%0h exp=%0h", sif.out_data, ew);
        end
        enable = 1'b0;
        repeat (2) tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL idle_after_accept got=%0b exp=0", busy);
        end
    endtask

    task automatic test_hold();
        logic [OUT_W-1:0] held;
        logic [31:0]      ew;
        int               cyc;
        sif.out_ready = 1'b0;
        do_seed(16'd884);
        checks++;
        if (state_out !== 16'd884) begin
            failures++; $display("FAIL hold_seed got=%0d exp=884", state_out);
        end
        push_words(16'd884, 1);
        enable = 1'b1;
        wait_valid(FIRST + 10, cyc);
        checks++;
        if (cyc !== FIRST) begin
            failures++; $display("FAIL hold_latency got=%0d exp=%0d", cyc, FIRST);
        end
        ew   = sb_pop();
        held = sif.out_data;
        checks++;
        if ({28'b0, held} !== ew) begin
            failures++; $display("FAIL hold_word got=%0h exp=%0h", held, ew);
        end
        for (int n = 0; n < 50; n++) begin
            tick();
            checks++;
            if (sif.out_valid !== 1'b1 || sif.out_data !== held) begin
                failures++;
                $display("FAIL hold_stable cyc=%0d got=%0b/%0h exp=1/%0h", n, sif.out_valid, sif.out_data, held);
            end
            checks++;
            if (busy !== 1'b0 || state_out !== 16'd14888) begin
                failures++;
                $display("FAIL hold_state cyc=%0d got=%0b/%0d exp=0/14888", n, busy, state_out);
            end
        end
        sif.out_ready = 1'b1;
        tick();
        sif.out_ready = 1'b0;
        checks++;
        if (sif.out_valid !== 1'b0) begin
            failures++; $display("FAIL hold_release_valid got=%0b exp=0", sif.out_valid);
        end
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL hold_release_busy got=%0b exp=1", busy);
        end
        enable = 1'b0;
        repeat (STEP + 2) tick();
        checks++;
        if (busy !== 1'b0 || state_out !== m_next(16'd14888)) begin
            failures++; $display("FAIL hold_next_step got=%0b/%0d exp=0/%0d", busy, state_out, m_next(16'd14888));
        end
    endtask

    task automatic test_seed_load();
        logic [SIZE-1:0] seeds [7];
        logic [SIZE-1:0] exps  [7];
        logic [31:0]     ew;
        int              cyc;
        seeds = '{16'd0, 16'd1, 16'd40633, 16'd65535, 16'd2, 16'd40632, 16'd884};
        exps  = '{16'd884, 16'd884, 16'd884, 16'd884, 16'd2, 16'd40632, 16'd884};
        for (int i = 0; i < 7; i++) begin
            enable        = 1'b0;
            sif.out_ready = 1'b0;
            do_seed(seeds[i]);
            checks++;
            if (state_out !== exps[i] || sif.out_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL seed_%0d got=%0d/%0b/%0b exp=%0d/0/0", seeds[i], state_out, sif.out_valid, busy, exps[i]);
            end
            push_words(exps[i], 1);
            enable        = 1'b1;
            sif.out_ready = 1'b1;
            wait_valid(FIRST + 10, cyc);
            ew = sb_pop();
            checks++;
            if (cyc !== FIRST || {28'b0, sif.out_data} !== ew) begin
                failures++;
                $display("FAIL seed_regen_%0d got=%0d/%0h exp=%0d/%0h", seeds[i], cyc, sif.out_data, FIRST, ew);
            end
            enable = 1'b0;
            tick();
        end
        // seed_load racing out_ready while a word is pending
        sif.out_ready = 1'b0;
        do_seed(16'd884);
        push_words(16'd884, 1);
        enable = 1'b1;
        wait_valid(FIRST + 10, cyc);
        ew = sb_pop();
        checks++;
        if ({28'b0, sif.out_data} !== ew) begin
            failures++; $display("FAIL pending_word got=%0h exp=%0h", sif.out_data, ew);
        end
        seed_in       = 16'd0;
        seed_load     = 1'b1;
        sif.out_ready = 1'b1;
        tick();
        seed_load     = 1'b0;
        sif.out_ready = 1'b0;
        enable        = 1'b0;
        checks++;
        if (sif.out_valid !== 1'b0 || state_out !== 16'd884 || busy !== 1'b0) begin
            failures++;
            $display("FAIL seed_vs_ready got=%0b/%0d/%0b exp=0/884/0", sif.out_valid, state_out, busy);
        end
        tick();
        checks++;
        if (sif.out_valid !== 1'b0) begin
            failures++; $display("FAIL seed_vs_ready_after got=%0b exp=0", sif.out_valid);
        end
    endtask

    task automatic test_enable_drop();
        logic [31:0] ew;
        int          cyc;
        do_seed(16'd884);
        push_words(16'd884, 1);
        enable        = 1'b1;
        sif.out_ready = 1'b1;
        repeat (40) tick();
        enable = 1'b0;
        repeat (5) tick();
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL drop_step_continues got=%0b exp=1", busy);
        end
        repeat (15) tick();
        checks++;
        if (state_out !== 16'd18911) begin
            failures++; $display("FAIL drop_commit got=%0d exp=18911", state_out);
        end
        checks++;
        if (busy !== 1'b0 || sif.out_valid !== 1'b0) begin
            failures++; $display("FAIL drop_idle got=%0b/%0b exp=0/0", busy, sif.out_valid);
        end
        enable = 1'b1;
        wait_valid(FIRST + 10, cyc);
        checks++;
        if (cyc !== STEP + 1) begin
            failures++; $display("FAIL resume_latency got=%0d exp=%0d", cyc, STEP + 1);
        end
        ew = sb_pop();
        checks++;
        if ({28'b0, sif.out_data} !== ew) begin
            failures++; $display("FAIL resume_word got=%0h exp=%0h", sif.out_data, ew);
        end
        enable = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        logic [31:0] ew;
        int          cyc;
        do_seed(16'd884);
        enable        = 1'b1;
        sif.out_ready = 1'b1;
        repeat (25) tick();
        checks++;
        if (state_out !== 16'd9429 || busy !== 1'b1) begin
            failures++; $display("FAIL pre_reset got=%0d/%0b exp=9429/1", state_out, busy);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (state_out !== 16'd884 || busy !== 1'b0 || sif.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_square got=%0d/%0b/%0b exp=884/0/0", state_out, busy, sif.out_valid);
        end
        tick();
        exp_q.delete();
        push_words(16'd884, 1);
        sif.out_ready = 1'b0;
        reset         = 1'b1;
        wait_valid(FIRST + 10, cyc);
        ew = sb_pop();
        checks++;
        if (cyc !== FIRST || {28'b0, sif.out_data} !== ew) begin
            failures++;
            $display("FAIL restart_word got=%0d/%0h exp=%0d/%0h", cyc, sif.out_data, FIRST, ew);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (sif.out_valid !== 1'b0 || sif.out_data !== 4'h0 || state_out !== 16'd884) begin
            failures++;
            $display("FAIL async_reset_hold got=%0b/%0h/%0d exp=0/0/884", sif.out_valid, sif.out_data, state_out);
        end
        tick();
        enable = 1'b0;
        reset  = 1'b1;
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_word();
        test_hold();
        test_seed_load();
        test_enable_drop();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
